// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder that streams packed instruction words into instruction memory.
// Illegal bundles are consumed without a write and raise a sticky error until the next start.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   LastCnt  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFull} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       enc;
    logic              legal;
    logic              accept;
    logic              depth_hit;

    logic i_ok;
    logic b_ok;
    logic j_ok;
    logic u_ok;

    assign i_ok = (imm[31:11] == {21{imm[11]}});
    assign b_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign j_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
    assign u_ok = (imm[11:0] == 12'd0);

    always_comb begin
        enc   = 32'd0;
        legal = 1'b0;
        case (op)
            OpR: begin
                enc   = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op};
                legal = 1'b1;
            end
            OpImm: begin
                // slli/srli/srai carry a 5-bit shamt with funct7 in the upper bits
                if (funct3[1:0] == 2'b01) begin
                    enc   = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, op};
                    legal = (imm[31:5] == 27'd0);
                end else begin
                    enc   = {imm[11:0], rs1, funct3, rd, op};
                    legal = i_ok;
                end
            end
            OpLoad, OpJalr: begin
                enc   = {imm[11:0], rs1, funct3, rd, op};
                legal = i_ok;
            end
            OpStore: begin
                enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                legal = i_ok;
            end
            OpBr: begin
                enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                legal = b_ok;
            end
            OpLui, OpAuipc: begin
                enc   = {imm[31:12], rd, op};
                legal = u_ok;
            end
            OpJal: begin
                enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                legal = j_ok;
            end
            default: begin
                enc   = 32'd0;
                legal = 1'b0;
            end
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign depth_hit = (word_count == LastCnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BaseAddr;
            imem_wdata <= 32'd0;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            wr_ptr     <= BaseAddr;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                StIdle, StFull: begin
                    if (start) begin
                        state      <= StRun;
                        in_ready   <= 1'b1;
                        full       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        wr_ptr     <= BaseAddr;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wr_ptr;
                            imem_wdata <= enc;
                            wr_ptr     <= wr_ptr + 1'b1;
                            word_count <= word_count + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        done <= in_last;
                        if (in_last) begin
                            state    <= StIdle;
                            in_ready <= 1'b0;
                            if (legal && depth_hit) full <= 1'b1;
                        end else if (legal && depth_hit) begin
                            state    <= StFull;
                            in_ready <= 1'b0;
                            full     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a small DEPTH and a BASE near the top of memory,
// so address wrap and the full condition are reachable in short sessions.
module tb_instr_encoder_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned BASE   = 62;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              full;
    logic              err;
    logic [ADDR_W:0]   word_count;

    int n_checks = 0;
    int n_errors = 0;

    instr_encoder_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .BASE  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .done      (done),
        .full      (full),
        .err       (err),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one bundle, waits (bounded) for in_ready, returns #1 after the accepting edge.
    task automatic push(input logic [6:0] p_op, input logic [2:0] p_f3, input logic p_f7,
                        input logic [4:0] p_rd, input logic [4:0] p_rs1, input logic [4:0] p_rs2,
                        input logic [31:0] p_imm, input logic p_last);
        int n;
        op       = p_op;
        funct3   = p_f3;
        funct7b5 = p_f7;
        rd       = p_rd;
        rs1      = p_rs1;
        rs2      = p_rs2;
        imm      = p_imm;
        in_last  = p_last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int we_seen;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        op       = 7'd0;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        rd       = 5'd0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        imm      = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we",    {31'd0, imem_we}, 32'd0);
        check("rst_addr",  {26'd0, imem_addr}, 32'd62);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_full",  {31'd0, full}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_cnt",   {25'd0, word_count}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        // addi x1,x0,5 as a single-word session
        do_start();
        check("start_ready", {31'd0, in_ready}, 32'd1);
        push(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        check("addi_we",    {31'd0, imem_we}, 32'd1);
        check("addi_addr",  {26'd0, imem_addr}, 32'd62);
        check("addi_wdata", imem_wdata, 32'h00500093);
        check("addi_done",  {31'd0, done}, 32'd1);
        check("addi_cnt",   {25'd0, word_count}, 32'd1);
        @(posedge clk);
        #1;
        check("addi_we_off",   {31'd0, imem_we}, 32'd0);
        check("addi_done_off", {31'd0, done}, 32'd0);
        check("addi_idle",     {31'd0, in_ready}, 32'd0);

        // add then sub, back-to-back
        do_start();
        push(7'b0110011, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        check("add_we",    {31'd0, imem_we}, 32'd1);
        check("add_addr",  {26'd0, imem_addr}, 32'd62);
        check("add_wdata", imem_wdata, 32'h002081B3);
        check("add_done",  {31'd0, done}, 32'd0);
        push(7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        check("sub_we",    {31'd0, imem_we}, 32'd1);
        check("sub_addr",  {26'd0, imem_addr}, 32'd63);
        check("sub_wdata", imem_wdata, 32'h402081B3);
        check("sub_done",  {31'd0, done}, 32'd1);
        check("sub_cnt",   {25'd0, word_count}, 32'd2);

        // sw, beq, jal (last); third word wraps to address 0
        do_start();
        push(7'b0100011, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        check("sw_wdata", imem_wdata, 32'h0020A423);
        check("sw_addr",  {26'd0, imem_addr}, 32'd62);
        push(7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
        check("beq_wdata", imem_wdata, 32'hFE208EE3);
        check("beq_addr",  {26'd0, imem_addr}, 32'd63);
        push(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        check("jal_wdata", imem_wdata, 32'h008000EF);
        check("jal_addr",  {26'd0, imem_addr}, 32'd0);
        check("jal_we",    {31'd0, imem_we}, 32'd1);
        check("jal_done",  {31'd0, done}, 32'd1);
        check("jal_full",  {31'd0, full}, 32'd0);

        // shift-immediate and U-type encodings
        do_start();
        push(7'b0010011, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0);
        check("slli_wdata", imem_wdata, 32'h00309093);
        push(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0);
        check("srai_wdata", imem_wdata, 32'h4030D093);
        push(7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        check("lui_wdata", imem_wdata, 32'h123452B7);
        check("lui_addr",  {26'd0, imem_addr}, 32'd0);

        // illegal bundles: misaligned branch, out-of-range addi (last)
        do_start();
        push(7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
        check("bad_beq_we",  {31'd0, imem_we}, 32'd0);
        check("bad_beq_err", {31'd0, err}, 32'd1);
        push(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1);
        check("bad_addi_we",   {31'd0, imem_we}, 32'd0);
        check("bad_addi_err",  {31'd0, err}, 32'd1);
        check("bad_addi_cnt",  {25'd0, word_count}, 32'd0);
        check("bad_addi_done", {31'd0, done}, 32'd1);
        do_start();
        check("err_cleared", {31'd0, err}, 32'd0);

        // fill DEPTH words with wrap, fifth bundle must be held
        for (int i = 0; i < 4; i++) begin
            push(7'b0010011, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
            check("fill_we",    {31'd0, imem_we}, 32'd1);
            check("fill_addr",  {26'd0, imem_addr}, (i < 2) ? 32'(62 + i) : 32'(i - 2));
            check("fill_wdata", imem_wdata, {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'b0010011});
        end
        check("full_set",   {31'd0, full}, 32'd1);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        check("full_cnt",   {25'd0, word_count}, 32'd4);
        check("full_done",  {31'd0, done}, 32'd0);
        in_valid = 1'b1;
        imm      = 32'd9;
        we_seen  = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (imem_we) we_seen++;
        end
        in_valid = 1'b0;
        check("held_no_we", 32'(we_seen), 32'd0);
        check("held_full",  {31'd0, full}, 32'd1);

        // restart from FULL, then reset mid-session with a bundle pending
        do_start();
        check("restart_full",  {31'd0, full}, 32'd0);
        check("restart_ready", {31'd0, in_ready}, 32'd1);
        push(7'b1111111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        check("bad_op_err", {31'd0, err}, 32'd1);
        push(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        check("pre_rst_we", {31'd0, imem_we}, 32'd1);
        in_valid = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_we",    {31'd0, imem_we}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_err",   {31'd0, err}, 32'd0);
        check("mid_rst_addr",  {26'd0, imem_addr}, 32'd62);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        check("mid_rst_cnt",   {25'd0, word_count}, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        we_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (imem_we) we_seen++;
        end
        in_valid = 1'b0;
        check("post_rst_no_we", 32'(we_seen), 32'd0);
        check("post_rst_ready", {31'd0, in_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
